seq_div: RTL and testbench
==========================

# seq_div

Sequential restoring divider that inverts the 5×5 Wallace-tree multiplier datapath. It divides a 10-bit unsigned dividend by a 5-bit unsigned divisor, producing one quotient bit per clock under a start/done handshake. It sits beside `wtm` in the arithmetic unit and checks its products (`a*b / b == a`, remainder 0).

## Interface
- `DIVIDEND_W`, default 10: dividend and quotient width. It equals the `wtm` product width.
- `DIVISOR_W`, default 5: divisor and remainder width. It equals the `wtm` operand width.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  request; sampled on the rising edge
- `dividend`  in  DIVIDEND_W  unsigned; captured when `start` is accepted
- `divisor`  in  DIVISOR_W  unsigned; captured when `start` is accepted
- `quotient`  out  DIVIDEND_W  result
- `remainder`  out  DIVISOR_W  result
- `busy`  out  1  high while iterating
- `done`  out  1  one-cycle pulse when results become valid
- `div_by_zero`  out  1  flag for a zero divisor; held with the results

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: iterating.
  - DONE: single-cycle result pulse.
- Start acceptance: `start` is accepted only in IDLE or DONE. `start` in RUN is ignored and has no effect on operands or state.
- On accept with `divisor != 0`:
  - Latch the divisor.
  - Load the quotient/shift register with `dividend`.
  - Clear the partial remainder (DIVISOR_W+1 bits).
  - Set the iteration counter to DIVIDEND_W.
  - Go to RUN.
- On accept with `divisor == 0`:
  - Go directly to DONE.
  - Set `quotient = all ones` (10'h3FF), `remainder = 0`, `div_by_zero = 1`.
- RUN step, once per cycle:
  - Shift the partial remainder left, taking in the dividend-register MSB: `r = {r[4:0], q[9]}`.
  - Shift `q` left.
  - If `r >= divisor`: `r = r - divisor` and `q[0] = 1`; otherwise `q[0] = 0`.
  - Decrement the counter. When it reaches 0, go to DONE.
- Width rules:
  - The partial remainder is 6 bits so the compare cannot overflow.
  - `remainder` is its low 5 bits, always `< divisor`.
  - All arithmetic is unsigned with no saturation.
- DONE:
  - `done = 1` for exactly one cycle, then go to IDLE (or to RUN/DONE if `start` is accepted that cycle).
- Result holding:
  - `quotient`, `remainder` and `div_by_zero` hold their values until the next accepted `start`.
  - `div_by_zero` clears on the next accepted start with a nonzero divisor.
- Operand stability: input operands may change freely after acceptance and do not affect the running operation.

## Timing
- Reset values (asynchronous, immediate): state IDLE; `quotient = 0`, `remainder = 0`, `busy = 0`, `done = 0`, `div_by_zero = 0`. Reset asserted mid-RUN aborts the operation and produces no `done`.
- Nonzero-divisor latency:
  - Accept edge is E0.
  - `busy` is high from after E0 through the cycle before DONE.
  - The 10 iterations occur on edges E1..E10.
  - `done = 1` and `busy = 0` in the cycle after E10.
  - Results are valid in the same cycle as `done`.
- Zero-divisor latency: `done` and `div_by_zero` are high in the cycle after E0. `busy` never rises.
- Back-to-back: `start` held high in the DONE cycle is accepted, so the next operation begins without an IDLE gap. Throughput is one result per 11 cycles.
- Concurrency: `busy` and `done` are never high together.

## Structure
- Shared package `div_pkg`:
  - `DIVIDEND_W`, `DIVISOR_W`
  - state encoding (IDLE=0, RUN=1, DONE=2)
  - `ITER_W = 4` (counter width)
  - `Q_DIV0 = 10'h3FF`
- One natural sub-module, `div_step`: combinational single-iteration cell.
  - Inputs: `r_in[5:0]`, `bit_in`, `divisor[4:0]`.
  - Outputs: `r_out[5:0]`, `q_bit`.
  - The top level holds only the FSM, counter and registers.

## Test plan
- Multiply inverse: `dividend=400`, `divisor=16` (25×16) -> `quotient=25`, `remainder=0`, `done` 11 cycles after `start`, `div_by_zero=0`.
- Multiply inverse: `dividend=961`, `divisor=31` -> `quotient=31`, `remainder=0`. Then `dividend=31`, `divisor=1` -> `quotient=31`, `remainder=0`.
- Nonzero remainder: `dividend=1000`, `divisor=7` -> `quotient=142`, `remainder=6`. Also `dividend=3`, `divisor=20` -> `quotient=0`, `remainder=3`.
- Divide by zero: `dividend=5`, `divisor=0` -> `done` and `div_by_zero` high 1 cycle after `start`, `quotient=10'h3FF`, `remainder=0`, `busy` stays 0.
- Start while busy: start 1000/7, then pulse `start` with 20/4 on cycle 5 -> ignored. Result is 142 rem 6. Then `start` held in the DONE cycle with 20/4 -> accepted, next `done` gives `quotient=5`, `remainder=0`.
- Reset mid-operation: assert `reset` on cycle 6 of 400/16 -> all outputs 0 immediately, state IDLE, no `done`. After release, 400/16 completes normally with `quotient=25`.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

  localparam int DIVIDEND_W = 10;
  localparam int DIVISOR_W  = 5;
  localparam int ITER_W     = 4;

  // Quotient reported for a zero divisor: all ones.
  localparam logic [DIVIDEND_W-1:0] Q_DIV0 = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift a dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module div_step #(
  parameter int DIVISOR_W = 5
) (
  input  logic [DIVISOR_W:0]   r_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   r_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] r_sh;
  logic [DIVISOR_W:0] dvs_ext;

  // The partial remainder carries one extra bit so the compare never overflows.
  always_comb begin
    r_sh    = {r_in[DIVISOR_W-1:0], bit_in};
    dvs_ext = {1'b0, divisor};
    q_bit   = (r_sh >= dvs_ext);
    r_out   = q_bit ? (r_sh - dvs_ext) : r_sh;
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, start/done
// handshake, zero-divisor short cut straight to DONE.
module seq_div #(
  parameter int DIVIDEND_W = 10,
  parameter int DIVISOR_W  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  import div_pkg::*;

  state_e                state_q, state_d;
  logic [ITER_W-1:0]     cnt_q, cnt_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W:0]    r_q, r_d;
  logic                  dbz_q, dbz_d;

  logic                  accept;
  logic                  div0;
  logic [DIVISOR_W:0]    step_r;
  logic                  step_q;

  // A request is only taken when no iteration is in flight.
  assign accept = start && (state_q != ST_RUN);
  assign div0   = (divisor == '0);

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .r_in    (r_q),
    .bit_in  (q_q[DIVIDEND_W-1]),
    .divisor (dvsr_q),
    .r_out   (step_r),
    .q_bit   (step_q)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DONE can chain straight into a new operation.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = div0 ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q == ITER_W'(1)) state_d = ST_DONE;
      ST_DONE: begin
        if (accept) state_d = div0 ? ST_DONE : ST_RUN;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  // Datapath next-state: load on accept, iterate while running, else hold.
  always_comb begin
    q_d    = q_q;
    r_d    = r_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    dbz_d  = dbz_q;
    if (accept) begin
      if (div0) begin
        q_d   = DIVIDEND_W'(Q_DIV0);
        r_d   = '0;
        dbz_d = 1'b1;
      end else begin
        dvsr_d = divisor;
        q_d    = dividend;
        r_d    = '0;
        cnt_d  = ITER_W'(DIVIDEND_W);
        dbz_d  = 1'b0;
      end
    end else if (state_q == ST_RUN) begin
      r_d   = step_r;
      q_d   = {q_q[DIVIDEND_W-2:0], step_q};
      cnt_d = cnt_q - ITER_W'(1);
    end
  end

  // Datapath registers; reset clears results so outputs read zero at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      r_q    <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      r_q    <= r_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient    = q_q;
  assign remainder   = r_q[DIVISOR_W-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div.
module tb_seq_div;

  logic       clock;
  logic       reset;
  logic       start;
  logic [9:0] dividend;
  logic [4:0] divisor;
  logic [9:0] quotient;
  logic [4:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_div dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a start at the next negedge; returns right after the accept edge (+1).
  task automatic issue(input logic [9:0] dvd, input logic [4:0] dvs);
    @(negedge clock);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom_range(1023, 0);
    divisor  = 5'($urandom_range(31, 0));
  endtask

  // Wait for done (sampled 1 after each edge), bounded; reports edges after accept.
  task automatic wait_done(input string tag, output int lat, output bit busy_seen);
    lat = 0;
    busy_seen = 0;
    while (!done && lat < 30) begin
      if (busy) busy_seen = 1;
      @(posedge clock);
      #1;
      lat++;
      if (busy && done) chk({tag, "_busy_and_done"}, 1, 0);
    end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic do_op(input string tag, input logic [9:0] dvd, input logic [4:0] dvs,
                       input logic [9:0] eq, input logic [4:0] er, input logic edbz,
                       input int elat);
    int lat;
    bit bs;
    issue(dvd, dvs);
    wait_done(tag, lat, bs);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, edbz);
    chk({tag, "_busy_seen"}, bs, (elat != 0));
    // done must be a single-cycle pulse
    @(posedge clock);
    #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int lat;
    bit bs;
    int cyc;
    int seen_done;

    start = 0;
    dividend = '0;
    divisor = '0;
    reset = 1;
    #1;
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;

    do_op("400_16",  10'd400,  5'd16, 10'd25,   5'd0, 0, 10);
    do_op("961_31",  10'd961,  5'd31, 10'd31,   5'd0, 0, 10);
    do_op("31_1",    10'd31,   5'd1,  10'd31,   5'd0, 0, 10);
    do_op("1000_7",  10'd1000, 5'd7,  10'd142,  5'd6, 0, 10);
    do_op("div0",    10'd5,    5'd0,  10'h3FF,  5'd0, 1, 0);
    do_op("3_20",    10'd3,    5'd20, 10'd0,    5'd3, 0, 10);
    do_op("1023_31", 10'd1023, 5'd31, 10'd33,   5'd0, 0, 10);
    do_op("1023_1",  10'd1023, 5'd1,  10'd1023, 5'd0, 0, 10);
    do_op("0_9",     10'd0,    5'd9,  10'd0,    5'd0, 0, 10);

    // Start while busy is ignored; start held in DONE is accepted.
    issue(10'd1000, 5'd7);
    chk("busy_after_accept", busy, 1);
    repeat (4) @(posedge clock);
    #1;
    dividend = 10'd20;
    divisor  = 5'd4;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("ignored_start_busy", busy, 1);
    wait_done("bb1", lat, bs);
    chk("bb1_lat", lat, 5);
    chk("bb1_q", quotient, 142);
    chk("bb1_r", remainder, 6);
    dividend = 10'd20;
    divisor  = 5'd4;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("bb2_busy", busy, 1);
    chk("bb2_no_done", done, 0);
    wait_done("bb2", lat, bs);
    chk("bb2_lat", lat, 10);
    chk("bb2_q", quotient, 5);
    chk("bb2_r", remainder, 0);

    // Zero divisor right after a result clears nothing until accepted.
    do_op("div0b", 10'd77, 5'd0, 10'h3FF, 5'd0, 1, 0);

    // Reset mid-operation aborts without done.
    issue(10'd400, 5'd16);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1;
    #1;
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    seen_done = 0;
    for (cyc = 0; cyc < 15; cyc++) begin
      @(posedge clock);
      #1;
      if (done || busy) seen_done = 1;
    end
    chk("mid_rst_idle", seen_done, 0);
    do_op("post_rst", 10'd400, 5'd16, 10'd25, 5'd0, 0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
